sim_exit_ctrl: RTL and testbench

Parametrised simulation-control block for multi-hart CV32E40P testbenches. It sequences core reset release and fetch enable, then aggregates per-hart pass/fail/exit events into one registered verdict. An optional cycle watchdog terminates runaway simulations. It sits between the bench clock/reset generator and N `cv32e40p_tb_subsystem` instances; the bench acts on `done_o`.

---
 rtl/sim_ctrl_pkg.sv | 21 ++
 rtl/sim_hart_outcome.sv | 20 ++
 rtl/sim_exit_ctrl.sv | 136 +++++++++++++
 tb/tb_sim_exit_ctrl.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sim_ctrl_pkg.sv
// Shared types for the simulation exit controller: verdict encoding, FSM states
// and the exit value reported when a failing hart supplied none.
package sim_ctrl_pkg;

  typedef enum logic [1:0] {
    SIM_NONE    = 2'd0,
    SIM_PASS    = 2'd1,
    SIM_FAIL    = 2'd2,
    SIM_TIMEOUT = 2'd3
  } sim_status_e;

  typedef enum logic [1:0] {
    S_WAIT = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } sim_fsm_e;

  // Sliced down to the exit value width at the point of use (width <= 64).
  localparam logic [63:0] SIM_EXIT_FAIL_NOVAL = '1;

endpackage

// File: rtl/sim_hart_outcome.sv
// Combinational per-hart event decode into success / failure.
// A non-zero exit value is a failure; failure masks a coincident success.
module sim_hart_outcome #(
  parameter int unsigned EXIT_VALUE_WIDTH = 32
) (
  input  logic                        passed_i,
  input  logic                        failed_i,
  input  logic                        exit_valid_i,
  input  logic [EXIT_VALUE_WIDTH-1:0] exit_value_i,
  output logic                        success_o,
  output logic                        failure_o
);

  logic exit_nz;

  assign exit_nz   = |exit_value_i;
  assign failure_o = failed_i | (exit_valid_i & exit_nz);
  assign success_o = (passed_i | (exit_valid_i & ~exit_nz)) & ~failure_o;

endmodule

// File: rtl/sim_exit_ctrl.sv
// Sequences core reset / fetch enable, then latches a sticky pass/fail/timeout verdict.
// Watchdog present only when SIM_EXIT_CTRL_WATCHDOG_EN is defined.
module sim_exit_ctrl
  import sim_ctrl_pkg::*;
#(
  parameter int unsigned NUM_HARTS         = 1,
  parameter int unsigned RESET_WAIT_CYCLES = 4,
  parameter int unsigned CYCLE_CNT_WIDTH   = 32,
  parameter int unsigned EXIT_VALUE_WIDTH  = 32,
  localparam int unsigned HART_IDX_W       = (NUM_HARTS > 1) ? $clog2(NUM_HARTS) : 1
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic [CYCLE_CNT_WIDTH-1:0]            max_cycles_i,
  input  logic [NUM_HARTS-1:0]                  hart_passed_i,
  input  logic [NUM_HARTS-1:0]                  hart_failed_i,
  input  logic [NUM_HARTS-1:0]                  hart_exit_valid_i,
  input  logic [NUM_HARTS*EXIT_VALUE_WIDTH-1:0] hart_exit_value_i,
  output logic                                  core_rst_no,
  output logic                                  fetch_enable_o,
  output logic                                  done_o,
  output logic [1:0]                            status_o,
  output logic [HART_IDX_W-1:0]                 fail_hart_o,
  output logic [EXIT_VALUE_WIDTH-1:0]           exit_value_o,
  output logic [CYCLE_CNT_WIDTH-1:0]            cycle_count_o
);

  localparam int unsigned WAIT_CNT_W = $clog2(RESET_WAIT_CYCLES + 1);
  localparam logic [EXIT_VALUE_WIDTH-1:0] NOVAL = SIM_EXIT_FAIL_NOVAL[EXIT_VALUE_WIDTH-1:0];

  sim_fsm_e                    state_q;
  sim_status_e                 status_q;
  logic [WAIT_CNT_W-1:0]       wait_cnt_q;
  logic [NUM_HARTS-1:0]        fin_q, fin_d;
  logic [CYCLE_CNT_WIDTH-1:0]  cycle_q;
  logic                        core_rst_n_q, fetch_en_q, done_q;
  logic [HART_IDX_W-1:0]       fail_hart_q, fail_idx;
  logic [EXIT_VALUE_WIDTH-1:0] exit_val_q, fail_val;
  logic [NUM_HARTS-1:0]        success, failure;
  logic                        fail_any, all_fin, wd_hit;

  for (genvar h = 0; h < NUM_HARTS; h++) begin : g_hart
    sim_hart_outcome #(.EXIT_VALUE_WIDTH(EXIT_VALUE_WIDTH)) u_outcome (
      .passed_i     (hart_passed_i[h]),
      .failed_i     (hart_failed_i[h]),
      .exit_valid_i (hart_exit_valid_i[h]),
      .exit_value_i (hart_exit_value_i[h*EXIT_VALUE_WIDTH +: EXIT_VALUE_WIDTH]),
      .success_o    (success[h]),
      .failure_o    (failure[h])
    );
  end

  // Descending scan so the lowest failing index is the one that sticks.
  always_comb begin
    fail_any = |failure;
    fail_idx = '0;
    fail_val = NOVAL;
    for (int h = NUM_HARTS - 1; h >= 0; h--) begin
      if (failure[h]) begin
        fail_idx = HART_IDX_W'(h);
        fail_val = hart_exit_valid_i[h] ? hart_exit_value_i[h*EXIT_VALUE_WIDTH +: EXIT_VALUE_WIDTH]
                                        : NOVAL;
      end
    end
    fin_d   = fin_q | success;
    all_fin = &fin_d;
  end

`ifdef SIM_EXIT_CTRL_WATCHDOG_EN
  assign wd_hit = (max_cycles_i != '0) && (cycle_q == max_cycles_i);
`else
  logic unused_max_cycles;
  assign unused_max_cycles = ^max_cycles_i;
  assign wd_hit            = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_WAIT;
      status_q     <= SIM_NONE;
      wait_cnt_q   <= '0;
      fin_q        <= '0;
      cycle_q      <= '0;
      core_rst_n_q <= 1'b0;
      fetch_en_q   <= 1'b0;
      done_q       <= 1'b0;
      fail_hart_q  <= '0;
      exit_val_q   <= '0;
    end else begin
      case (state_q)
        S_WAIT: begin
          wait_cnt_q <= wait_cnt_q + 1'b1;
          if (wait_cnt_q == WAIT_CNT_W'(RESET_WAIT_CYCLES - 1)) begin
            state_q      <= S_RUN;
            core_rst_n_q <= 1'b1;
            fetch_en_q   <= 1'b1;
          end
        end
        S_RUN: begin
          fin_q <= fin_d;
          // Count is frozen on the edge that enters DONE.
          if (fail_any) begin
            state_q     <= S_DONE;
            done_q      <= 1'b1;
            fetch_en_q  <= 1'b0;
            status_q    <= SIM_FAIL;
            fail_hart_q <= fail_idx;
            exit_val_q  <= fail_val;
          end else if (all_fin) begin
            state_q    <= S_DONE;
            done_q     <= 1'b1;
            fetch_en_q <= 1'b0;
            status_q   <= SIM_PASS;
          end else if (wd_hit) begin
            state_q    <= S_DONE;
            done_q     <= 1'b1;
            fetch_en_q <= 1'b0;
            status_q   <= SIM_TIMEOUT;
          end else if (cycle_q != '1) begin
            cycle_q <= cycle_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign core_rst_no    = core_rst_n_q;
  assign fetch_enable_o = fetch_en_q;
  assign done_o         = done_q;
  assign status_o       = status_q;
  assign fail_hart_o    = fail_hart_q;
  assign exit_value_o   = exit_val_q;
  assign cycle_count_o  = cycle_q;

endmodule

// File: tb/tb_sim_exit_ctrl.sv
// Bench for sim_exit_ctrl: directed scenarios plus randomized events against an event-level model.
module tb_sim_exit_ctrl;

  localparam int NH  = 4;
  localparam int RWC = 4;
  localparam int CW  = 32;
  localparam int EW  = 32;
`ifdef SIM_EXIT_CTRL_WATCHDOG_EN
  localparam bit WD = 1'b1;
`else
  localparam bit WD = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [CW-1:0]    max_cycles = '0;
  logic [NH-1:0]    passed = '0, failed = '0, ev = '0;
  logic [NH*EW-1:0] val = '0;
  logic             core_rst_n, fetch_en, done;
  logic [1:0]       status;
  logic [1:0]       fail_hart;
  logic [EW-1:0]    exit_val;
  logic [CW-1:0]    cnt;

  sim_exit_ctrl #(.NUM_HARTS(NH), .RESET_WAIT_CYCLES(RWC), .CYCLE_CNT_WIDTH(CW), .EXIT_VALUE_WIDTH(EW)) dut (
    .clk(clk), .rst_n(rst_n), .max_cycles_i(max_cycles),
    .hart_passed_i(passed), .hart_failed_i(failed), .hart_exit_valid_i(ev), .hart_exit_value_i(val),
    .core_rst_no(core_rst_n), .fetch_enable_o(fetch_en), .done_o(done), .status_o(status),
    .fail_hart_o(fail_hart), .exit_value_o(exit_val), .cycle_count_o(cnt)
  );

  // Narrow counter instance to reach saturation quickly.
  logic [5:0]  s_max = '0;
  logic        s_zero = 1'b0;
  logic [31:0] s_val = '0;
  logic        s_core_rst_n, s_fe, s_done;
  logic [1:0]  s_status;
  logic [0:0]  s_fail_hart;
  logic [31:0] s_exit;
  logic [5:0]  s_cnt;

  sim_exit_ctrl #(.NUM_HARTS(1), .RESET_WAIT_CYCLES(RWC), .CYCLE_CNT_WIDTH(6), .EXIT_VALUE_WIDTH(32)) u_sat (
    .clk(clk), .rst_n(rst_n), .max_cycles_i(s_max),
    .hart_passed_i(s_zero), .hart_failed_i(s_zero), .hart_exit_valid_i(s_zero), .hart_exit_value_i(s_val),
    .core_rst_no(s_core_rst_n), .fetch_enable_o(s_fe), .done_o(s_done), .status_o(s_status),
    .fail_hart_o(s_fail_hart), .exit_value_o(s_exit), .cycle_count_o(s_cnt)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: edges since reset, sticky per-hart finish flags, verdict fields.
  int            m_edges;
  bit            m_done;
  logic [1:0]    m_status;
  int            m_fail_hart;
  logic [EW-1:0] m_exit;
  longint        m_cnt;
  bit            m_fin[NH];

  function automatic void model_reset();
    m_edges = 0; m_done = 0; m_status = 2'd0; m_fail_hart = 0; m_exit = '0; m_cnt = 0;
    for (int h = 0; h < NH; h++) m_fin[h] = 0;
  endfunction

  function automatic void model_edge();
    int lowest;
    bit all_done;
    logic [EW-1:0] v;
    bit f, s;
    if (m_done) return;
    if (m_edges < RWC) begin
      m_edges++;
      return;
    end
    lowest = -1;
    for (int h = 0; h < NH; h++) begin
      v = val[h*EW +: EW];
      f = failed[h] || (ev[h] && v != 0);
      s = passed[h] || (ev[h] && v == 0);
      if (f && lowest < 0) lowest = h;
      if (s) m_fin[h] = 1;
    end
    all_done = 1;
    for (int h = 0; h < NH; h++) all_done &= m_fin[h];
    if (lowest >= 0) begin
      m_done = 1; m_status = 2'd2; m_fail_hart = lowest;
      m_exit = ev[lowest] ? val[lowest*EW +: EW] : {EW{1'b1}};
    end else if (all_done) begin
      m_done = 1; m_status = 2'd1;
    end else if (WD && max_cycles != 0 && m_cnt == longint'(max_cycles)) begin
      m_done = 1; m_status = 2'd3;
    end else if (m_cnt < ((longint'(1) << CW) - 1)) begin
      m_cnt++;
    end
  endfunction

  task automatic clear_inputs();
    passed = '0; failed = '0; ev = '0; val = '0;
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    clear_inputs();
    max_cycles = '0;
    model_reset();
    #2;
    rst_n = 1'b1;
  endtask

  task automatic goto_run();
    do_reset();
    repeat (RWC) step();
  endtask

  task automatic test_reset();
    do_reset();
    total++; if (core_rst_n !== 1'b0) begin bad++; $display("FAIL reset_core_rst got=%0b exp=0", core_rst_n); end
    total++; if (fetch_en !== 1'b0) begin bad++; $display("FAIL reset_fetch got=%0b exp=0", fetch_en); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%0b exp=0", done); end
    total++; if (status !== 2'd0) begin bad++; $display("FAIL reset_status got=%0d exp=0", status); end
    total++; if (fail_hart !== 2'd0) begin bad++; $display("FAIL reset_fail_hart got=%0d exp=0", fail_hart); end
    total++; if (exit_val !== 32'h0) begin bad++; $display("FAIL reset_exit got=%0h exp=0", exit_val); end
    total++; if (cnt !== 32'h0) begin bad++; $display("FAIL reset_cnt got=%0d exp=0", cnt); end
    for (int e = 1; e <= 6; e++) begin
      // Hart events during WAIT must be ignored.
      failed = (e == 2) ? 4'b0001 : 4'b0000;
      step();
      failed = '0;
      total++; if (core_rst_n !== (e >= 4)) begin bad++; $display("FAIL seq_core_rst edge=%0d got=%0b exp=%0b", e, core_rst_n, e >= 4); end
      total++; if (fetch_en !== (e >= 4)) begin bad++; $display("FAIL seq_fetch edge=%0d got=%0b exp=%0b", e, fetch_en, e >= 4); end
    end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL wait_ignored_done got=%0b exp=0", done); end
  endtask

  task automatic test_pass_sequence();
    goto_run();
    for (int c = 1; c <= 25; c++) begin
      passed[0] = (c == 10) || (c == 15);
      passed[1] = (c == 12);
      passed[2] = (c == 12);
      passed[3] = (c == 20);
      step();
      clear_inputs();
      total++; if (done !== (c >= 20)) begin bad++; $display("FAIL pass_done cyc=%0d got=%0b exp=%0b", c, done, c >= 20); end
    end
    total++; if (status !== 2'd1) begin bad++; $display("FAIL pass_status got=%0d exp=1", status); end
    total++; if (cnt !== 32'd19) begin bad++; $display("FAIL pass_cnt_frozen got=%0d exp=19", cnt); end
    total++; if (fetch_en !== 1'b0) begin bad++; $display("FAIL pass_fetch got=%0b exp=0", fetch_en); end
    total++; if (core_rst_n !== 1'b1) begin bad++; $display("FAIL pass_core_rst got=%0b exp=1", core_rst_n); end
  endtask

  task automatic test_fail_priority();
    goto_run();
    repeat (3) step();
    ev[2] = 1'b1; val[2*EW +: EW] = 32'h5; failed[1] = 1'b1;
    step();
    clear_inputs();
    total++; if (done !== 1'b1) begin bad++; $display("FAIL fail_done got=%0b exp=1", done); end
    total++; if (status !== 2'd2) begin bad++; $display("FAIL fail_status got=%0d exp=2", status); end
    total++; if (fail_hart !== 2'd1) begin bad++; $display("FAIL fail_hart got=%0d exp=1", fail_hart); end
    total++; if (exit_val !== 32'hFFFF_FFFF) begin bad++; $display("FAIL fail_exit got=%0h exp=ffffffff", exit_val); end
    total++; if (fetch_en !== 1'b0) begin bad++; $display("FAIL fail_fetch got=%0b exp=0", fetch_en); end
    total++; if (core_rst_n !== 1'b1) begin bad++; $display("FAIL fail_core_rst got=%0b exp=1", core_rst_n); end
    passed = '1; failed[0] = 1'b1;
    repeat (5) step();
    clear_inputs();
    total++; if (status !== 2'd2 || fail_hart !== 2'd1) begin bad++; $display("FAIL fail_frozen got=%0d/%0d exp=2/1", status, fail_hart); end
    // Exit-value path: hart 0 succeeds via zero exit, hart 3 fails with a value.
    goto_run();
    step();
    ev = 4'b1001; val[3*EW +: EW] = 32'h1234; val[0 +: EW] = 32'h0;
    step();
    clear_inputs();
    total++; if (fail_hart !== 2'd3) begin bad++; $display("FAIL exit_hart got=%0d exp=3", fail_hart); end
    total++; if (exit_val !== 32'h1234) begin bad++; $display("FAIL exit_value got=%0h exp=1234", exit_val); end
  endtask

  task automatic test_watchdog();
    int edges;
    goto_run();
    max_cycles = 32'd100;
    edges = 0;
    while (done !== 1'b1 && edges < 250) begin
      step();
      edges++;
    end
    if (WD) begin
      total++; if (status !== 2'd3) begin bad++; $display("FAIL wd_status got=%0d exp=3", status); end
      total++; if (cnt !== 32'd100) begin bad++; $display("FAIL wd_cnt got=%0d exp=100", cnt); end
      total++; if (edges !== 101) begin bad++; $display("FAIL wd_latency got=%0d exp=101", edges); end
    end else begin
      total++; if (done !== 1'b0) begin bad++; $display("FAIL nowd_done got=%0b exp=0", done); end
      total++; if (cnt !== 32'd250) begin bad++; $display("FAIL nowd_cnt got=%0d exp=250", cnt); end
    end
  endtask

  task automatic test_watchdog_tie();
    goto_run();
    max_cycles = 32'd50;
    repeat (50) step();
    failed[0] = 1'b1;
    step();
    clear_inputs();
    total++; if (status !== 2'd2 || done !== 1'b1) begin bad++; $display("FAIL tie_fail got=%0d/%0b exp=2/1", status, done); end
    goto_run();
    max_cycles = 32'd50;
    repeat (4) step();
    passed = 4'b0111;
    step();
    clear_inputs();
    repeat (45) step();
    passed[3] = 1'b1;
    step();
    clear_inputs();
    total++; if (status !== 2'd1 || done !== 1'b1) begin bad++; $display("FAIL tie_pass got=%0d/%0b exp=1/1", status, done); end
    total++; if (cnt !== 32'd50) begin bad++; $display("FAIL tie_pass_cnt got=%0d exp=50", cnt); end
  endtask

  task automatic test_async_reset();
    goto_run();
    failed[2] = 1'b1;
    step();
    clear_inputs();
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    total++; if ({core_rst_n, fetch_en, done} !== 3'b000) begin bad++; $display("FAIL arst_ctrl got=%b exp=000", {core_rst_n, fetch_en, done}); end
    total++; if (status !== 2'd0 || fail_hart !== 2'd0 || exit_val !== 32'h0 || cnt !== 32'h0) begin
      bad++; $display("FAIL arst_fields got=%0d/%0d/%0h/%0d exp=0/0/0/0", status, fail_hart, exit_val, cnt);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int e = 1; e <= RWC; e++) begin
      step();
      total++; if (core_rst_n !== (e == RWC)) begin bad++; $display("FAIL arst_restart edge=%0d got=%0b exp=%0b", e, core_rst_n, e == RWC); end
    end
  endtask

  task automatic test_saturate();
    do_reset();
    repeat (RWC + 30) step();
    total++; if (s_cnt !== 6'd30) begin bad++; $display("FAIL sat_mid got=%0d exp=30", s_cnt); end
    repeat (70) step();
    total++; if (s_cnt !== 6'd63) begin bad++; $display("FAIL sat_top got=%0d exp=63", s_cnt); end
    total++; if (s_done !== 1'b0) begin bad++; $display("FAIL sat_done got=%0b exp=0", s_done); end
  endtask

  task automatic test_random();
    for (int ep = 0; ep < 8; ep++) begin
      do_reset();
      max_cycles = ($urandom_range(0, 2) == 0) ? '0 : CW'($urandom_range(5, 60));
      for (int c = 0; c < 130; c++) begin
        for (int h = 0; h < NH; h++) begin
          passed[h] = ($urandom_range(0, 29) == 0);
          failed[h] = ($urandom_range(0, 299) == 0);
          ev[h]     = ($urandom_range(0, 79) == 0);
          val[h*EW +: EW] = ($urandom_range(0, 1) == 0) ? 32'h0 : 32'($urandom_range(1, 9));
        end
        if ($urandom_range(0, 39) == 0) max_cycles = CW'($urandom_range(0, 70));
        step();
        total++; if (core_rst_n !== (m_edges >= RWC)) begin bad++; $display("FAIL rnd_core_rst ep=%0d c=%0d got=%0b exp=%0b", ep, c, core_rst_n, m_edges >= RWC); end
        total++; if (fetch_en !== (m_edges >= RWC && !m_done)) begin bad++; $display("FAIL rnd_fetch ep=%0d c=%0d got=%0b", ep, c, fetch_en); end
        total++; if (done !== m_done) begin bad++; $display("FAIL rnd_done ep=%0d c=%0d got=%0b exp=%0b", ep, c, done, m_done); end
        total++; if (status !== m_status) begin bad++; $display("FAIL rnd_status ep=%0d c=%0d got=%0d exp=%0d", ep, c, status, m_status); end
        total++; if (fail_hart !== 2'(m_fail_hart)) begin bad++; $display("FAIL rnd_fail_hart ep=%0d c=%0d got=%0d exp=%0d", ep, c, fail_hart, m_fail_hart); end
        total++; if (exit_val !== m_exit) begin bad++; $display("FAIL rnd_exit ep=%0d c=%0d got=%0h exp=%0h", ep, c, exit_val, m_exit); end
        total++; if (cnt !== m_cnt[CW-1:0]) begin bad++; $display("FAIL rnd_cnt ep=%0d c=%0d got=%0d exp=%0d", ep, c, cnt, m_cnt); end
      end
    end
    clear_inputs();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "simulation time limit");
  end

  initial begin
    model_reset();
    test_reset();
    test_pass_sequence();
    test_fail_priority();
    test_watchdog();
    test_watchdog_tie();
    test_async_reset();
    test_saturate();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
